lsu_mem_ctrl: RTL and testbench
===============================

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-002 SHALL have these EXU-side ports: ex_valid_i  in  1  instr valid; ex_ready_o  out  1  LSU can accept; ex_mem_ren_i / ex_mem_wen_i  in  1 each  load / store; ex_funct3_i  in  3  size/sign (RV64 LB..LWU, SB..SD); ex_mem_addr_i  in  64  byte address; ex_mem_wdata_i  in  64  store data (LSBs).
REQ-003 SHALL have these EXU-side passthrough ports: ex_reg_wen_i 1, ex_reg_waddr_i 5, ex_reg_wdata_i 64 (ALU result), ex_csr_wen_i 1, ex_csr_waddr_i 12, ex_csr_wdata_i 64, ex_pc_i 64, ex_inst_i 32.
REQ-004 SHALL have these WBU-side outputs: wb_valid_o 1, wb_reg_wen_o 1, wb_reg_waddr_o 5, wb_reg_wdata_o 64, wb_csr_wen_o 1, wb_csr_waddr_o 12, wb_csr_wdata_o 64, wb_pc_o 64, wb_inst_o 32, wb_misalign_o 1.
REQ-005 SHALL have these memory-bus ports: mem_req_o out 1; mem_we_o out 1; mem_addr_o out 64 (doubleword-aligned, addr[2:0]=0); mem_wdata_o out 64; mem_wstrb_o out 8; mem_gnt_i in 1 (request accepted); mem_rvalid_i in 1 (response / store ack); mem_rdata_i in 64.

Function
REQ-006 SHALL implement FSM IDLE, REQ, WAIT, DONE; ex_ready_o=1 only in IDLE.
REQ-007 SHALL, in IDLE with ex_valid_i=1, capture all ex_* inputs into registers and go to DONE if neither ren nor wen is set, else to REQ.
REQ-008 SHALL, in REQ, hold mem_req_o=1 with stable mem_we_o/addr/wdata/wstrb until mem_gnt_i=1.
REQ-009 SHALL move REQ->WAIT on gnt without rvalid, and REQ->DONE if gnt and rvalid occur in the same cycle.
REQ-010 SHALL, in WAIT, stay until mem_rvalid_i=1, then go to DONE; mem_req_o=0 in WAIT.
REQ-011 SHALL capture mem_rdata_i in the cycle rvalid is seen and ignore rvalid in IDLE/DONE.
REQ-012 SHALL, in DONE, assert wb_valid_o=1 for exactly one cycle, then return to IDLE; WBU always consumes it.
REQ-013 SHALL gate wb_reg_wen_o and wb_csr_wen_o with wb_valid_o; other wb_* outputs are the registered values.
REQ-014 SHALL, for loads, set wb_reg_wdata_o = rdata >> (addr[2:0]*8), truncated to 8/16/32/64 bits, sign-extended for LB/LH/LW and zero-extended for LBU/LHU/LWU; for non-loads, the registered ex_reg_wdata_i.
REQ-015 SHALL, for stores, drive mem_wdata_o = wdata << (addr[2:0]*8) and wstrb = {1,3,F,FF}[size] << addr[2:0].
REQ-016 SHALL make latency, counted from the accept cycle N, equal to wb_valid_o at N+1 for a non-memory instruction and N+3 for gnt in the first REQ cycle with rvalid one cycle later.

Reset
REQ-017 SHALL, on rst_n=0, asynchronously enter IDLE and drive every output and register to 0, with ex_ready_o=1 after release.
REQ-018 SHALL, on reset asserted mid-operation (REQ/WAIT), abandon the pending access with no wb_valid_o; a late rvalid after release is ignored per REQ-011.

Configuration
REQ-019 SHALL, when macro LSU_MISALIGN_CHECK_EN is defined, flag accesses not aligned to their size: skip REQ/WAIT, go IDLE->DONE, set wb_misalign_o=1 with wb_valid_o and force wb_reg_wen_o=0.
REQ-020 SHALL, without LSU_MISALIGN_CHECK_EN, tie wb_misalign_o to 0 and issue all accesses as-is; crossing the doubleword drops the out-of-range bytes.

Verification
REQ-021 SHALL cover a non-memory instruction: ALU inst, reg_wdata=0x1234, waddr=5 -> wb_valid_o at N+1, wb_reg_wdata_o=0x1234, wb_reg_wen_o=1 for one cycle.
REQ-022 SHALL cover LB: addr=0x8000_0003, rdata=0x0000_0000_8000_0000 -> wb_reg_wdata_o=0xFFFF_FFFF_FFFF_FF80; LBU of the same gives 0x80.
REQ-023 SHALL cover SH: addr=0x8000_0006, wdata=0xBEEF -> mem_wdata_o=0xBEEF_0000_0000_0000, mem_wstrb_o=0xC0, mem_we_o=1.
REQ-024 SHALL cover stalls: gnt delayed 3 cycles, rvalid 2 cycles later -> request fields stable throughout, ex_ready_o=0, a single wb_valid_o pulse.
REQ-025 SHALL cover same-cycle gnt+rvalid, where LD gives wb_valid_o at N+2; and rst_n pulsed in WAIT gives no wb_valid_o and all outputs 0.
REQ-026 SHALL cover, with LSU_MISALIGN_CHECK_EN, LW at 0x8000_0002 -> no mem_req_o, wb_misalign_o=1, wb_reg_wen_o=0 at N+1.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit between EXU and WBU.
// Accepts one instruction at a time. Memory instructions run a single
// doubleword-aligned bus access with req/gnt/rvalid handshake. The
// writeback fields are presented for exactly one cycle in DONE.
// Optional build macro: LSU_MISALIGN_CHECK_EN. When it is defined,
// accesses not aligned to their size skip the bus and are flagged on
// wb_misalign_o.
module lsu_mem_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    // EXU side
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic        ex_mem_ren_i,
    input  logic        ex_mem_wen_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [63:0] ex_mem_addr_i,
    input  logic [63:0] ex_mem_wdata_i,
    input  logic        ex_reg_wen_i,
    input  logic [4:0]  ex_reg_waddr_i,
    input  logic [63:0] ex_reg_wdata_i,
    input  logic        ex_csr_wen_i,
    input  logic [11:0] ex_csr_waddr_i,
    input  logic [63:0] ex_csr_wdata_i,
    input  logic [63:0] ex_pc_i,
    input  logic [31:0] ex_inst_i,
    // WBU side
    output logic        wb_valid_o,
    output logic        wb_reg_wen_o,
    output logic [4:0]  wb_reg_waddr_o,
    output logic [63:0] wb_reg_wdata_o,
    output logic        wb_csr_wen_o,
    output logic [11:0] wb_csr_waddr_o,
    output logic [63:0] wb_csr_wdata_o,
    output logic [63:0] wb_pc_o,
    output logic [31:0] wb_inst_o,
    output logic        wb_misalign_o,
    // Memory bus
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    output logic [7:0]  mem_wstrb_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [63:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Everything the writeback stage needs, captured at accept time.
    // reg_wdata is overwritten with the extracted load value on response.
    typedef struct packed {
        logic        reg_wen;
        logic [4:0]  reg_waddr;
        logic [63:0] reg_wdata;
        logic        csr_wen;
        logic [11:0] csr_waddr;
        logic [63:0] csr_wdata;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        ren;
        logic [2:0]  funct3;
        logic [2:0]  boff;
        logic        misalign;
    } ctx_t;

    state_e      state_q, state_d;
    ctx_t        ctx_q, ctx_d;
    logic        mem_we_q, mem_we_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]  mem_wstrb_q, mem_wstrb_d;
    logic        mis_w;

    // Shift the addressed bytes down to bit 0, then truncate and extend.
    function automatic logic [63:0] load_extract(input logic [63:0] rdata,
                                                 input logic [2:0]  boff,
                                                 input logic [2:0]  f3);
        logic [63:0] sh;
        logic        sx;
        sh = rdata >> {boff, 3'b000};
        sx = ~f3[2];
        case (f3[1:0])
            2'd0:    return {{56{sx & sh[7]}},  sh[7:0]};
            2'd1:    return {{48{sx & sh[15]}}, sh[15:0]};
            2'd2:    return {{32{sx & sh[31]}}, sh[31:0]};
            default: return sh;
        endcase
    endfunction

    // Byte lanes for the access size, moved to the byte offset. Lanes past
    // bit 7 fall off, which drops bytes that would cross the doubleword.
    function automatic logic [7:0] store_strb(input logic [2:0] f3,
                                              input logic [2:0] boff);
        logic [7:0] base;
        case (f3[1:0])
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << boff;
    endfunction

`ifdef LSU_MISALIGN_CHECK_EN
    logic [2:0] size_mask;

    // Memory access is misaligned when any offset bit below its size is set.
    always_comb begin
        case (ex_funct3_i[1:0])
            2'd0:    size_mask = 3'b000;
            2'd1:    size_mask = 3'b001;
            2'd2:    size_mask = 3'b011;
            default: size_mask = 3'b111;
        endcase
        mis_w = (ex_mem_ren_i | ex_mem_wen_i) & (|(ex_mem_addr_i[2:0] & size_mask));
    end
`else
    assign mis_w = 1'b0;
`endif

    // Next-state, capture of EXU fields and load response.
    always_comb begin
        state_d     = state_q;
        ctx_d       = ctx_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        case (state_q)
            S_IDLE: begin
                if (ex_valid_i) begin
                    ctx_d.reg_wen   = ex_reg_wen_i;
                    ctx_d.reg_waddr = ex_reg_waddr_i;
                    ctx_d.reg_wdata = ex_reg_wdata_i;
                    ctx_d.csr_wen   = ex_csr_wen_i;
                    ctx_d.csr_waddr = ex_csr_waddr_i;
                    ctx_d.csr_wdata = ex_csr_wdata_i;
                    ctx_d.pc        = ex_pc_i;
                    ctx_d.inst      = ex_inst_i;
                    ctx_d.ren       = ex_mem_ren_i;
                    ctx_d.funct3    = ex_funct3_i;
                    ctx_d.boff      = ex_mem_addr_i[2:0];
                    ctx_d.misalign  = mis_w;
                    mem_we_d        = ex_mem_wen_i;
                    mem_addr_d      = {ex_mem_addr_i[63:3], 3'b000};
                    mem_wdata_d     = ex_mem_wdata_i << {ex_mem_addr_i[2:0], 3'b000};
                    mem_wstrb_d     = store_strb(ex_funct3_i, ex_mem_addr_i[2:0]);
                    if (!(ex_mem_ren_i || ex_mem_wen_i) || mis_w)
                        state_d = S_DONE;
                    else
                        state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    if (mem_rvalid_i) begin
                        state_d = S_DONE;
                        if (ctx_q.ren)
                            ctx_d.reg_wdata = load_extract(mem_rdata_i, ctx_q.boff, ctx_q.funct3);
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = S_DONE;
                    if (ctx_q.ren)
                        ctx_d.reg_wdata = load_extract(mem_rdata_i, ctx_q.boff, ctx_q.funct3);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured fields; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ctx_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            ctx_q       <= ctx_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    // ex_ready_o is held low while reset is asserted so all outputs read 0.
    assign ex_ready_o     = rst_n & (state_q == S_IDLE);
    assign wb_valid_o     = (state_q == S_DONE);
    assign wb_reg_wen_o   = wb_valid_o & ctx_q.reg_wen & ~ctx_q.misalign;
    assign wb_reg_waddr_o = ctx_q.reg_waddr;
    assign wb_reg_wdata_o = ctx_q.reg_wdata;
    assign wb_csr_wen_o   = wb_valid_o & ctx_q.csr_wen;
    assign wb_csr_waddr_o = ctx_q.csr_waddr;
    assign wb_csr_wdata_o = ctx_q.csr_wdata;
    assign wb_pc_o        = ctx_q.pc;
    assign wb_inst_o      = ctx_q.inst;
`ifdef LSU_MISALIGN_CHECK_EN
    assign wb_misalign_o  = wb_valid_o & ctx_q.misalign;
`else
    assign wb_misalign_o  = 1'b0;
`endif

    assign mem_req_o      = (state_q == S_REQ);
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign mem_wstrb_o    = mem_wstrb_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed table plus randomized transactions against a
// byte-arithmetic reference model, and a reset-in-WAIT sequence.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid_i, ex_ready_o, ex_mem_ren_i, ex_mem_wen_i;
    logic [2:0]  ex_funct3_i;
    logic [63:0] ex_mem_addr_i, ex_mem_wdata_i, ex_reg_wdata_i, ex_csr_wdata_i, ex_pc_i;
    logic        ex_reg_wen_i, ex_csr_wen_i;
    logic [4:0]  ex_reg_waddr_i;
    logic [11:0] ex_csr_waddr_i;
    logic [31:0] ex_inst_i;
    logic        wb_valid_o, wb_reg_wen_o, wb_csr_wen_o, wb_misalign_o;
    logic [4:0]  wb_reg_waddr_o;
    logic [63:0] wb_reg_wdata_o, wb_csr_wdata_o, wb_pc_o;
    logic [11:0] wb_csr_waddr_o;
    logic [31:0] wb_inst_o;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [63:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [7:0]  mem_wstrb_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .ex_mem_ren_i(ex_mem_ren_i), .ex_mem_wen_i(ex_mem_wen_i),
        .ex_funct3_i(ex_funct3_i), .ex_mem_addr_i(ex_mem_addr_i),
        .ex_mem_wdata_i(ex_mem_wdata_i),
        .ex_reg_wen_i(ex_reg_wen_i), .ex_reg_waddr_i(ex_reg_waddr_i),
        .ex_reg_wdata_i(ex_reg_wdata_i), .ex_csr_wen_i(ex_csr_wen_i),
        .ex_csr_waddr_i(ex_csr_waddr_i), .ex_csr_wdata_i(ex_csr_wdata_i),
        .ex_pc_i(ex_pc_i), .ex_inst_i(ex_inst_i),
        .wb_valid_o(wb_valid_o), .wb_reg_wen_o(wb_reg_wen_o),
        .wb_reg_waddr_o(wb_reg_waddr_o), .wb_reg_wdata_o(wb_reg_wdata_o),
        .wb_csr_wen_o(wb_csr_wen_o), .wb_csr_waddr_o(wb_csr_waddr_o),
        .wb_csr_wdata_o(wb_csr_wdata_o), .wb_pc_o(wb_pc_o),
        .wb_inst_o(wb_inst_o), .wb_misalign_o(wb_misalign_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    typedef struct {
        logic        ren, wen, rw;
        logic [2:0]  f3;
        logic [4:0]  waddr;
        logic [63:0] addr, wdata, alu, rdata;
        int          gdly, rdly;
        logic [63:0] e_wb, e_mw;
        logic [7:0]  e_st;
        int          e_lat;
        bit          mis;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---- reference model: byte arithmetic on the spec rules ----
    function automatic logic [63:0] m_load(logic [63:0] rdata, logic [63:0] addr, logic [2:0] f3);
        int n = 1 << f3[1:0];
        int off = int'(addr % 64'd8);
        logic [63:0] v, mask;
        v = rdata >> (off * 8);
        mask = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (n * 8)) - 64'd1);
        v = v & mask;
        if (!f3[2] && n < 8 && v[n*8-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [7:0] m_strb(logic [63:0] addr, logic [2:0] f3);
        int s = ((1 << (1 << f3[1:0])) - 1) << int'(addr % 64'd8);
        return s[7:0];
    endfunction

    function automatic bit m_mis(logic ren, logic wen, logic [2:0] f3, logic [63:0] addr);
`ifdef LSU_MISALIGN_CHECK_EN
        return (ren | wen) && ((addr % (64'd1 << f3[1:0])) != 64'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic vec_t mk(logic ren, logic wen, logic [2:0] f3, logic [63:0] addr,
                                logic [63:0] wdata, logic [63:0] rdata, int g, int r);
        vec_t v;
        v.ren = ren; v.wen = wen; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.gdly = g; v.rdly = r;
        v.rw = 1'($urandom); v.waddr = 5'($urandom); v.alu = {$urandom, $urandom};
        v.mis   = m_mis(ren, wen, f3, addr);
        v.e_lat = (v.mis || !(ren | wen)) ? 1 : 2 + g + r;
        v.e_wb  = (ren && !v.mis) ? m_load(rdata, addr, f3) : v.alu;
        v.e_mw  = wdata << (8 * int'(addr % 64'd8));
        v.e_st  = m_strb(addr, f3);
        return v;
    endfunction

    // Directed vector with hand-computed expectations.
    function automatic vec_t tv(logic ren, logic wen, logic [2:0] f3, logic [63:0] addr,
                                logic [63:0] wdata, logic [63:0] rdata, int g, int r,
                                logic [63:0] e_wb, logic [63:0] e_mw, logic [7:0] e_st,
                                int e_lat, bit mis);
        vec_t v;
        v.ren = ren; v.wen = wen; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.gdly = g; v.rdly = r; v.rw = 1'b1; v.waddr = 5'd5;
        v.alu = 64'h1234; v.e_wb = e_wb; v.e_mw = e_mw; v.e_st = e_st;
        v.e_lat = e_lat; v.mis = mis;
        return v;
    endfunction

    task automatic scramble_ex();
        ex_mem_ren_i = 1'($urandom); ex_mem_wen_i = 1'($urandom);
        ex_funct3_i = 3'($urandom); ex_mem_addr_i = {$urandom, $urandom};
        ex_mem_wdata_i = {$urandom, $urandom}; ex_reg_wen_i = 1'($urandom);
        ex_reg_waddr_i = 5'($urandom); ex_reg_wdata_i = {$urandom, $urandom};
        ex_csr_wen_i = 1'($urandom); ex_csr_waddr_i = 12'($urandom);
        ex_csr_wdata_i = {$urandom, $urandom}; ex_pc_i = {$urandom, $urandom};
        ex_inst_i = $urandom;
    endtask

    // One instruction end to end, with a bus responder shaped by gdly/rdly.
    task automatic run(input string nm, input vec_t v);
        logic        cw = 1'($urandom);
        logic [11:0] ca = 12'($urandom);
        logic [63:0] cd = {$urandom, $urandom};
        logic [63:0] pc = {$urandom, $urandom};
        logic [31:0] ins = $urandom;
        int lat = -1, pulses = 0, reqc = 0, gcyc = -1;
        @(negedge clk);
        chk({nm, ".ready_idle"}, 64'(ex_ready_o), 64'd1);
        ex_valid_i = 1'b1; ex_mem_ren_i = v.ren; ex_mem_wen_i = v.wen;
        ex_funct3_i = v.f3; ex_mem_addr_i = v.addr; ex_mem_wdata_i = v.wdata;
        ex_reg_wen_i = v.rw; ex_reg_waddr_i = v.waddr; ex_reg_wdata_i = v.alu;
        ex_csr_wen_i = cw; ex_csr_waddr_i = ca; ex_csr_wdata_i = cd;
        ex_pc_i = pc; ex_inst_i = ins;
        for (int k = 1; k <= v.gdly + v.rdly + 6; k++) begin
            @(negedge clk);
            ex_valid_i = 1'b0;
            scramble_ex();
            if (mem_req_o) begin
                reqc++;
                chk({nm, ".mem_addr"}, mem_addr_o, v.addr & ~64'd7);
                chk({nm, ".mem_we"}, 64'(mem_we_o), 64'(v.wen));
                if (v.wen) begin
                    chk({nm, ".mem_wdata"}, mem_wdata_o, v.e_mw);
                    chk({nm, ".mem_wstrb"}, 64'(mem_wstrb_o), 64'(v.e_st));
                end
                mem_gnt_i = (reqc == v.gdly + 1);
                if (mem_gnt_i) gcyc = k;
            end else begin
                mem_gnt_i = 1'b0;
            end
            mem_rvalid_i = (gcyc >= 0) && (k == gcyc + v.rdly);
            mem_rdata_i = mem_rvalid_i ? v.rdata : {$urandom, $urandom};
            if (wb_valid_o) begin
                pulses++;
                if (lat < 0) lat = k;
                chk({nm, ".wb_wdata"}, wb_reg_wdata_o, v.e_wb);
                chk({nm, ".wb_reg_wen"}, 64'(wb_reg_wen_o), 64'(v.rw & ~v.mis));
                chk({nm, ".wb_waddr"}, 64'(wb_reg_waddr_o), 64'(v.waddr));
                chk({nm, ".wb_csr"}, {wb_csr_wen_o, wb_csr_waddr_o, wb_inst_o}, {cw, ca, ins});
                chk({nm, ".wb_csr_wdata"}, wb_csr_wdata_o, cd);
                chk({nm, ".wb_pc"}, wb_pc_o, pc);
                chk({nm, ".wb_misalign"}, 64'(wb_misalign_o), 64'(v.mis));
            end else begin
                chk({nm, ".wen_gated"}, {62'd0, wb_reg_wen_o, wb_csr_wen_o}, 64'd0);
            end
            chk({nm, ".ready"}, 64'(ex_ready_o), (lat >= 0 && k > lat) ? 64'd1 : 64'd0);
        end
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        chk({nm, ".latency"}, 64'(lat), 64'(v.e_lat));
        chk({nm, ".pulses"}, 64'(pulses), 64'd1);
        chk({nm, ".req_cycles"}, 64'(reqc), (v.e_lat == 1) ? 64'd0 : 64'(v.gdly + 1));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".flags"}, {32'd0, ex_ready_o, wb_valid_o, wb_reg_wen_o, wb_csr_wen_o,
             wb_misalign_o, mem_req_o, mem_we_o, wb_reg_waddr_o, wb_csr_waddr_o, mem_wstrb_o}, 64'd0);
        chk({nm, ".wb_wdata"}, wb_reg_wdata_o, 64'd0);
        chk({nm, ".wb_csr_wdata"}, wb_csr_wdata_o, 64'd0);
        chk({nm, ".wb_pc_inst"}, wb_pc_o | 64'(wb_inst_o), 64'd0);
        chk({nm, ".mem_addr_wdata"}, mem_addr_o | mem_wdata_o, 64'd0);
    endtask

    // Reset pulsed while waiting for rvalid; the late rvalid must be ignored.
    task automatic reset_in_wait();
        int pulses = 0;
        @(negedge clk);
        ex_valid_i = 1'b1; ex_mem_ren_i = 1'b1; ex_mem_wen_i = 1'b0; ex_funct3_i = 3'd3;
        ex_mem_addr_i = 64'h8000_0040; ex_reg_wen_i = 1'b1; ex_csr_wen_i = 1'b1;
        ex_pc_i = 64'h8000_1000; ex_inst_i = 32'h0000_3003;
        @(negedge clk);
        ex_valid_i = 1'b0;
        chk("rstw.req", 64'(mem_req_o), 64'd1);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        chk("rstw.wait_noreq", 64'(mem_req_o | wb_valid_o), 64'd0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rstw");
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            if (wb_valid_o) pulses++;
            chk("rstw.ready", 64'(ex_ready_o), 64'd1);
        end
        chk("rstw.no_wb", 64'(pulses), 64'd0);
        chk("rstw.wb_wdata", wb_reg_wdata_o, 64'd0);
    endtask

    vec_t tab[$];

    initial begin
        vec_t v;
        logic [2:0] f3;
        int kind;
        logic [63:0] a;
        ex_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        scramble_ex();
        ex_valid_i = 1'b0;

        // ALU, LB/LBU sign cases, SH, stalls, same-cycle gnt+rvalid, LH/LHU high half
        tab.push_back(tv(0, 0, 3'd0, 64'h0, 64'h0, 64'h0, 0, 0, 64'h1234, 64'h0, 8'h0, 1, 0));
        tab.push_back(tv(1, 0, 3'd0, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 0, 1,
                         64'hFFFF_FFFF_FFFF_FF80, 64'h0, 8'h0, 3, 0));
        tab.push_back(tv(1, 0, 3'd4, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 0, 1,
                         64'h80, 64'h0, 8'h0, 3, 0));
        tab.push_back(tv(0, 1, 3'd1, 64'h8000_0006, 64'hBEEF, 64'h0, 0, 1,
                         64'h1234, 64'hBEEF_0000_0000_0000, 8'hC0, 3, 0));
        tab.push_back(tv(1, 0, 3'd3, 64'h8000_0010, 64'h0, 64'h0123_4567_89AB_CDEF, 3, 2,
                         64'h0123_4567_89AB_CDEF, 64'h0, 8'h0, 7, 0));
        tab.push_back(tv(1, 0, 3'd3, 64'h8000_0018, 64'h0, 64'hFEDC_BA98_7654_3210, 0, 0,
                         64'hFEDC_BA98_7654_3210, 64'h0, 8'h0, 2, 0));
        tab.push_back(tv(1, 0, 3'd1, 64'h8000_0006, 64'h0, 64'hF00D_0000_0000_0000, 1, 0,
                         64'hFFFF_FFFF_FFFF_F00D, 64'h0, 8'h0, 3, 0));
        tab.push_back(tv(1, 0, 3'd5, 64'h8000_0006, 64'h0, 64'hF00D_0000_0000_0000, 0, 2,
                         64'hF00D, 64'h0, 8'h0, 4, 0));
`ifdef LSU_MISALIGN_CHECK_EN
        tab.push_back(tv(1, 0, 3'd2, 64'h8000_0002, 64'h0, 64'h1122_3344_8566_7788, 0, 1,
                         64'h1234, 64'h0, 8'h0, 1, 1));
`else
        tab.push_back(tv(1, 0, 3'd2, 64'h8000_0002, 64'h0, 64'h1122_3344_8566_7788, 0, 1,
                         64'h3344_8566, 64'h0, 8'h0, 3, 0));
        tab.push_back(tv(0, 1, 3'd2, 64'h8000_0006, 64'hAABB_CCDD, 64'h0, 0, 1,
                         64'h1234, 64'hCCDD_0000_0000_0000, 8'hC0, 3, 0));
`endif

        #3;
        chk_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tab[i]) run($sformatf("vec%0d", i), tab[i]);

        reset_in_wait();

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            f3 = (kind == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
            v = mk(kind == 1, kind == 2, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 3), $urandom_range(0, 3));
            run($sformatf("rnd%0d", i), v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
